// File: rtl/dsp_valid_tracker.sv
// Valid-token pipe that mirrors the DSP48A1 register stages (D/B0, A1/B1, M, P)
// so OUT_VALID lines up with P, plus in-flight accounting and a flush/drain handshake.
module dsp_valid_tracker #(
    parameter bit STAGE0REG = 1'b1,
    parameter bit STAGE1REG = 1'b1,
    parameter bit MREG      = 1'b1,
    parameter bit PREG      = 1'b1,
    parameter     RSTTYPE   = "SYNC"
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CEN,
    input  logic       IN_VALID,
    input  logic       FLUSH,
    output logic       OUT_VALID,
    output logic [2:0] INFLIGHT,
    output logic       BUSY,
    output logic       DONE,
    output logic [2:0] LATENCY
);

    localparam logic [3:0] STAGE_EN = {PREG, MREG, STAGE1REG, STAGE0REG};
    localparam logic [2:0] LAT      = 3'(STAGE0REG) + 3'(STAGE1REG) + 3'(MREG) + 3'(PREG);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_RUN       = 2'd1;
    localparam logic [1:0] S_DRAIN     = 2'd2;
    localparam logic [1:0] S_DONE_HOLD = 2'd3;

    if (RSTTYPE != "SYNC") begin : g_bad_rsttype
        $error("dsp_valid_tracker: RSTTYPE must be SYNC");
    end

    logic [3:0] v_q, v_d;
    logic [2:0] inflight_q, inflight_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [1:0] state_q, state_d;
    logic       tok_in;
    logic       s0_out, s1_out, s2_out, s3_out;

    assign tok_in = IN_VALID & ~FLUSH & (state_q != S_DONE_HOLD);

    // A bypassed stage passes its input straight through; its flop is held at 0.
    assign s0_out = STAGE_EN[0] ? v_q[0] : tok_in;
    assign s1_out = STAGE_EN[1] ? v_q[1] : s0_out;
    assign s2_out = STAGE_EN[2] ? v_q[2] : s1_out;
    assign s3_out = STAGE_EN[3] ? v_q[3] : s2_out;

    always_comb begin
        v_d    = '0;
        v_d[0] = STAGE_EN[0] & (CEN ? tok_in : v_q[0]);
        v_d[1] = STAGE_EN[1] & (CEN ? s0_out : v_q[1]);
        v_d[2] = STAGE_EN[2] & (CEN ? s1_out : v_q[2]);
        v_d[3] = STAGE_EN[3] & (CEN ? s2_out : v_q[3]);
        inflight_d = {2'b00, v_d[0]} + {2'b00, v_d[1]} + {2'b00, v_d[2]} + {2'b00, v_d[3]};
        busy_d     = (inflight_d != 3'd0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (FLUSH && inflight_q == 3'd0)
                    state_d = S_DONE_HOLD;
                else if (tok_in && CEN && LAT != 3'd0)
                    state_d = S_RUN;
            end
            S_RUN: begin
                if (FLUSH)
                    state_d = S_DRAIN;
                else if (inflight_d == 3'd0 && !tok_in)
                    state_d = S_IDLE;
            end
            S_DRAIN: begin
                // Abandoned flush resumes wherever the token count says; draining needs CEN.
                if (!FLUSH)
                    state_d = (inflight_d != 3'd0) ? S_RUN : S_IDLE;
                else if (CEN && inflight_d == 3'd0)
                    state_d = S_DONE_HOLD;
            end
            S_DONE_HOLD: begin
                if (!FLUSH)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        done_d = (state_d == S_DONE_HOLD) && (state_q != S_DONE_HOLD);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            v_q        <= '0;
            inflight_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            state_q    <= S_IDLE;
        end else begin
            v_q        <= v_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            state_q    <= state_d;
        end
    end

    assign OUT_VALID = s3_out;
    assign INFLIGHT  = inflight_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign LATENCY   = LAT;

endmodule

// File: doc/dsp_valid_tracker.md
# dsp_valid_tracker

Control-side companion to the DSP48A1 datapath registers: carries a single-bit valid token through the same configurable register stages that the data passes through (pre-adder input, multiplier input, M, P). The result is an OUT_VALID that is cycle-aligned with the P output. The block sits beside the DSP slice and shares its clock, clock enable and reset. It also provides in-flight accounting and a flush/drain handshake, so upstream logic knows when the pipeline is empty.

## Interface
- STAGE0REG, 1: D/B0 input register stage present (1) or bypassed (0)
- STAGE1REG, 1: A1/B1 register stage present (1) or bypassed (0)
- MREG, 1: multiplier output register stage present (1) or bypassed (0)
- PREG, 1: P output register stage present (1) or bypassed (0)
- RSTTYPE, "SYNC": fixed at "SYNC"; any other value is a configuration error (elaboration-time check)
- CLK  in  1  single clock, rising edge
- RST  in  1  synchronous reset, active-high
- CEN  in  1  shared clock enable; identical to the CEN driving the DSP datapath registers
- IN_VALID  in  1  operand presented to the DSP this cycle is valid
- FLUSH  in  1  level request: stop accepting tokens and drain the pipeline
- OUT_VALID  out  1  P output carries a valid result
- INFLIGHT  out  3  number of valid tokens held in enabled stages (0..4)
- BUSY  out  1  INFLIGHT != 0
- DONE  out  1  one-cycle pulse: drain completed
- LATENCY  out  3  constant STAGE0REG+STAGE1REG+MREG+PREG

## Operation
- Token pipe: 4 stage bits v0..v3, one per parameter.
  - A bypassed stage is a wire.
  - An enabled stage loads its input only when CEN=1 and holds otherwise.
  - This matches the datapath register semantics.
- Accepted token: tok_in = IN_VALID & ~FLUSH & (state != DONE_HOLD).
- OUT_VALID = output of the last stage.
  - If LATENCY=0, OUT_VALID = tok_in combinationally.
- INFLIGHT = popcount of the enabled stage bits only. Registered, updated every cycle.
- FSM states: IDLE, RUN, DRAIN, DONE_HOLD.
  - IDLE -> RUN: tok_in=1 with CEN=1 and LATENCY>0.
  - IDLE -> DONE_HOLD: FLUSH=1 with INFLIGHT=0. DONE pulses the next cycle.
  - RUN -> DRAIN: FLUSH=1.
  - RUN -> IDLE: next INFLIGHT=0 and no token accepted.
  - DRAIN -> DONE_HOLD: next INFLIGHT=0. DONE=1 for exactly one cycle on entry.
  - DRAIN -> RUN or IDLE: FLUSH drops before empty. The target follows INFLIGHT. No DONE.
  - DONE_HOLD -> IDLE: FLUSH=0.
- Draining advances only on CEN=1. With CEN held low, DRAIN waits indefinitely and DONE never fires.
- Reset (RST=1 at an edge, priority over CEN, any state including mid-drain):
  - all stage bits 0, state IDLE;
  - OUT_VALID=0 (when LATENCY>0), INFLIGHT=0, BUSY=0, DONE=0.

## Timing
- Latency: a token accepted at edge k (CEN=1) appears on OUT_VALID after LATENCY further CEN=1 edges.
  - CEN=0 cycles stretch the latency one-for-one.
  - OUT_VALID stays stable while CEN=0.
- Throughput: one token per CEN=1 cycle. Back-to-back tokens produce back-to-back OUT_VALID.
- INFLIGHT, BUSY, DONE and the state are registered. They reflect the edge just taken.
- FLUSH is sampled at the same edge as IN_VALID. A token coincident with the FLUSH rise is rejected.
- Simultaneous RST and FLUSH: RST wins; the state is IDLE.
- DONE never coincides with OUT_VALID=1 of a drained token. It follows the cycle in which the last token leaves.

## Test plan
- Full latency: defaults (LATENCY=4), CEN=1, one-cycle IN_VALID at cycle 10 -> OUT_VALID high only in cycle 14; INFLIGHT goes 1,1,1,1,0.
- Stall: defaults, token at cycle 10, CEN=0 for cycles 12-14 -> OUT_VALID at cycle 17; INFLIGHT constant during the stall.
- Bypass: all params 0 -> OUT_VALID follows IN_VALID the same cycle; INFLIGHT=0 always; FLUSH -> DONE one cycle later.
- Drain: MREG=PREG=1, others 0, tokens at cycles 5-8, FLUSH from cycle 8 -> token 8 rejected, three OUT_VALID pulses (cycles 7-9), DONE at cycle 10, IDLE after FLUSH drops.
- Reset mid-drain: defaults, 3 tokens in flight, state DRAIN, RST at cycle 20 -> cycle 21 shows INFLIGHT=0, OUT_VALID=0, DONE=0, state IDLE; no later DONE.
- Aborted flush: FLUSH pulsed for 1 cycle with 2 tokens in flight -> no DONE; both OUT_VALID pulses delivered; returns to IDLE.
